// File: rtl/ddr2_bridge.sv
// ddr2_bridge
//   Memory-side responder for the data cache miss path. Accepts one
//   single-word read or write request at a time from the cache controller
//   and turns it into command / write-data transactions on a MIG-style DDR2
//   user interface with 128-bit lines. Returns read data or a write
//   acknowledgement as a one-cycle resp_valid pulse.
//
// Configuration macro:
//   DDR2_BRIDGE_LINE_BUF_EN - when defined, a one-entry line buffer keeps the
//   last line read from memory; reads that hit it skip the DDR2 access, and
//   writes to the buffered line update it alongside memory.
//
// Ports:
//   clk, rst                  - ui_clk domain clock, synchronous active-high reset
//   init_calib_complete       - MIG calibration done; gates new requests
//   req_valid/req_ready       - cache request handshake
//   req_write, req_addr, req_wdata - request kind, byte address, write data
//   resp_valid, resp_rdata    - one-cycle response pulse and read data
//   app_addr/app_cmd/app_en/app_rdy           - MIG command channel
//   app_wdf_data/mask/wren/end, app_wdf_rdy   - MIG write-data channel
//   app_rd_data, app_rd_data_valid            - MIG read-data channel
module ddr2_bridge #(
  parameter int LINE_W = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_calib_complete,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [26:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic [26:0]           app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [LINE_W-1:0]     app_wdf_data,
  output logic [LINE_W/8-1:0]   app_wdf_mask,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  input  logic                  app_wdf_rdy,
  input  logic [LINE_W-1:0]     app_rd_data,
  input  logic                  app_rd_data_valid
);

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CMD,
    S_RD_WAIT,
    S_WR_DATA,
    S_WR_CMD,
    S_RESP,
    S_HIT
  } state_t;

  state_t     state;
  logic [1:0] ws;   // word select of the outstanding request

  // Byte-address bits [1:0] are ignored by this interface.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[1:0];

  // Byte-enable mask with only the 4 lanes of word w enabled (0 = write).
  function automatic logic [15:0] mask_for(input logic [1:0] w);
    logic [15:0] m;
    m = 16'hFFFF;
    m[{w, 2'b00} +: 4] = 4'h0;
    return m;
  endfunction

`ifdef DDR2_BRIDGE_LINE_BUF_EN
  logic              buf_valid;
  logic [22:0]       buf_tag;
  logic [LINE_W-1:0] buf_line;
  logic              buf_hit;
  assign buf_hit = buf_valid && (buf_tag == req_addr[26:4]);

  // NOTE: the line storage carries no reset; buf_valid alone decides whether
  // its contents mean anything, so only the valid bit needs clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
    end else if (state == S_IDLE && req_valid && req_ready && req_write && buf_hit) begin
      buf_line[{req_addr[3:2], 5'd0} +: 32] <= req_wdata;
    end else if (state == S_RD_WAIT && app_rd_data_valid) begin
      buf_valid <= 1'b1;
      buf_tag   <= app_addr[26:4];
      buf_line  <= app_rd_data;
    end
  end
`endif

  // Single FSM process; every output is a register updated here.
  // NOTE: all state and outputs use non-blocking assignments so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      ws           <= 2'd0;
      req_ready    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'd0;
      app_addr     <= 27'd0;
      app_cmd      <= CMD_WRITE;
      app_en       <= 1'b0;
      app_wdf_data <= '0;
      app_wdf_mask <= '1;
      app_wdf_wren <= 1'b0;
      app_wdf_end  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            ws        <= req_addr[3:2];
            app_addr  <= {req_addr[26:4], 4'b0000};
            if (req_write) begin
              app_cmd      <= CMD_WRITE;
              app_wdf_data <= {(LINE_W/32){req_wdata}};
              app_wdf_mask <= mask_for(req_addr[3:2]);
              app_wdf_wren <= 1'b1;
              app_wdf_end  <= 1'b1;
              state        <= S_WR_DATA;
            end else begin
              app_cmd <= CMD_READ;
`ifdef DDR2_BRIDGE_LINE_BUF_EN
              if (buf_hit) begin
                state <= S_HIT;
              end else begin
                app_en <= 1'b1;
                state  <= S_RD_CMD;
              end
`else
              app_en <= 1'b1;
              state  <= S_RD_CMD;
`endif
            end
          end else begin
            // Registered, so calibration reaches req_ready one cycle later.
            req_ready <= init_calib_complete;
          end
        end

        S_RD_CMD: begin
          if (app_rdy) begin
            app_en <= 1'b0;
            state  <= S_RD_WAIT;
          end
        end

        S_RD_WAIT: begin
          if (app_rd_data_valid) begin
            resp_rdata <= app_rd_data[{ws, 5'd0} +: 32];
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
        end

        S_WR_DATA: begin
          if (app_wdf_rdy) begin
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
            app_en       <= 1'b1;
            state        <= S_WR_CMD;
          end
        end

        S_WR_CMD: begin
          if (app_rdy) begin
            app_en     <= 1'b0;
            resp_rdata <= 32'd0;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
        end

`ifdef DDR2_BRIDGE_LINE_BUF_EN
        // Buffer hit: one extra cycle keeps the hit response at T+2.
        S_HIT: begin
          resp_rdata <= buf_line[{ws, 5'd0} +: 32];
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
`endif

        S_RESP: begin
          resp_valid <= 1'b0;
          resp_rdata <= 32'd0;
          req_ready  <= init_calib_complete;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr2_bridge.sv
// Directed testbench for ddr2_bridge. The bench plays the MIG side by hand,
// cycle by cycle: inputs change and outputs are sampled on the falling edge.
module tb_ddr2_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         init_calib_complete;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [26:0]  req_addr;
  logic [31:0]  req_wdata;
  logic         resp_valid;
  logic [31:0]  resp_rdata;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;

  int total = 0;
  int bad   = 0;
  int cmd_cnt = 0;
  int wdf_cnt = 0;

  always #5 clk = ~clk;

  ddr2_bridge #(.LINE_W(128)) dut (
    .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
  );

  // Advance one clock, counting handshakes that the coming edge completes.
  task automatic step();
    if (app_en && app_rdy) cmd_cnt++;
    if (app_wdf_wren && app_wdf_rdy) wdf_cnt++;
    @(negedge clk);
  endtask

  // Present a request for exactly one edge; req_ready must already be high.
  task automatic accept(input logic wr, input logic [26:0] a, input logic [31:0] d, input string nm);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL %s_ready got=%0b exp=1", nm, req_ready); end
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0;
  endtask

  // Memory read with minimum latency: app_rdy at T+1, data at T+2, resp at T+3.
  task automatic read_mem(input logic [26:0] a, input logic [26:0] exp_addr,
                          input logic [127:0] line, input logic [31:0] exp, input string nm);
    accept(1'b0, a, 32'd0, nm);
    total++; if (app_en !== 1'b1) begin bad++; $display("FAIL %s_en got=%0b exp=1", nm, app_en); end
    total++; if (app_cmd !== 3'b001) begin bad++; $display("FAIL %s_cmd got=%0b exp=001", nm, app_cmd); end
    total++; if (app_addr !== exp_addr) begin bad++; $display("FAIL %s_addr got=%h exp=%h", nm, app_addr, exp_addr); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL %s_busy got=%0b exp=0", nm, req_ready); end
    app_rdy = 1'b1; step(); app_rdy = 1'b0;
    total++; if (app_en !== 1'b0) begin bad++; $display("FAIL %s_en_drop got=%0b exp=0", nm, app_en); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL %s_early got=%0b exp=0", nm, resp_valid); end
    app_rd_data = line; app_rd_data_valid = 1'b1; step(); app_rd_data_valid = 1'b0;
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL %s_resp got=%0b exp=1", nm, resp_valid); end
    total++; if (resp_rdata !== exp) begin bad++; $display("FAIL %s_rdata got=%h exp=%h", nm, resp_rdata, exp); end
    step();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL %s_pulse got=%0b exp=0", nm, resp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL %s_ready_back got=%0b exp=1", nm, req_ready); end
  endtask

  // Memory write with minimum latency: wdf_rdy at T+1, app_rdy at T+2, resp at T+3.
  task automatic write_mem(input logic [26:0] a, input logic [31:0] d, input logic [26:0] exp_addr,
                           input logic [15:0] exp_mask, input string nm);
    accept(1'b1, a, d, nm);
    total++; if (app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1) begin bad++; $display("FAIL %s_wren got=%0b%0b exp=11", nm, app_wdf_wren, app_wdf_end); end
    total++; if (app_wdf_mask !== exp_mask) begin bad++; $display("FAIL %s_mask got=%h exp=%h", nm, app_wdf_mask, exp_mask); end
    total++; if (app_wdf_data !== {4{d}}) begin bad++; $display("FAIL %s_wdata got=%h exp=%h", nm, app_wdf_data, {4{d}}); end
    total++; if (app_en !== 1'b0) begin bad++; $display("FAIL %s_en_early got=%0b exp=0", nm, app_en); end
    app_wdf_rdy = 1'b1; step(); app_wdf_rdy = 1'b0;
    total++; if (app_en !== 1'b1 || app_wdf_wren !== 1'b0) begin bad++; $display("FAIL %s_cmdphase got=%0b%0b exp=10", nm, app_en, app_wdf_wren); end
    total++; if (app_cmd !== 3'b000) begin bad++; $display("FAIL %s_cmd got=%0b exp=000", nm, app_cmd); end
    total++; if (app_addr !== exp_addr) begin bad++; $display("FAIL %s_addr got=%h exp=%h", nm, app_addr, exp_addr); end
    app_rdy = 1'b1; step(); app_rdy = 1'b0;
    total++; if (resp_valid !== 1'b1 || resp_rdata !== 32'd0) begin bad++; $display("FAIL %s_resp got=%0b/%h exp=1/0", nm, resp_valid, resp_rdata); end
    total++; if (app_en !== 1'b0) begin bad++; $display("FAIL %s_en_drop got=%0b exp=0", nm, app_en); end
    step();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL %s_pulse got=%0b exp=0", nm, resp_valid); end
  endtask

  task automatic test_reset();
    rst = 1'b1; init_calib_complete = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data = '0; app_rd_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%0b exp=0", req_ready); end
    total++; if (resp_valid !== 1'b0 || resp_rdata !== 32'd0) begin bad++; $display("FAIL rst_resp got=%0b/%h exp=0/0", resp_valid, resp_rdata); end
    total++; if (app_en !== 1'b0 || app_wdf_wren !== 1'b0 || app_wdf_end !== 1'b0) begin bad++; $display("FAIL rst_strobes got=%0b%0b%0b exp=000", app_en, app_wdf_wren, app_wdf_end); end
    total++; if (app_addr !== 27'd0 || app_cmd !== 3'd0) begin bad++; $display("FAIL rst_addr_cmd got=%h/%0b exp=0/0", app_addr, app_cmd); end
    total++; if (app_wdf_data !== 128'd0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", app_wdf_data); end
    total++; if (app_wdf_mask !== 16'hFFFF) begin bad++; $display("FAIL rst_mask got=%h exp=ffff", app_wdf_mask); end
  endtask

  task automatic test_calib_gating();
    rst = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 27'h000_001C;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (req_ready !== 1'b0 || app_en !== 1'b0) begin bad++; $display("FAIL calib_gate got=%0b/%0b exp=0/0", req_ready, app_en); end
    end
    init_calib_complete = 1'b1;
    req_valid = 1'b0;
    step();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL calib_open got=%0b exp=1", req_ready); end
  endtask

  task automatic test_read_ws();
    read_mem(27'h000_001C, 27'h10,
             128'h44444444_33333333_22222222_11111111, 32'h44444444, "read_ws");
  endtask

  task automatic test_write_mask();
    write_mem(27'h000_0108, 32'hDEADBEEF, 27'h100, 16'hF0FF, "write_mask");
  endtask

  task automatic test_backpressure();
    cmd_cnt = 0; wdf_cnt = 0;
    accept(1'b1, 27'h000_0204, 32'h12345678, "bp");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      total++; if (app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1 || app_en !== 1'b0) begin bad++; $display("FAIL bp_wdf_hold%0d got=%0b%0b%0b exp=110", i, app_wdf_wren, app_wdf_end, app_en); end
      total++; if (app_wdf_data !== {4{32'h12345678}} || app_wdf_mask !== 16'hFF0F || app_addr !== 27'h200) begin bad++; $display("FAIL bp_wdf_data%0d got=%h/%h/%h", i, app_wdf_data, app_wdf_mask, app_addr); end
    end
    app_wdf_rdy = 1'b1; step(); app_wdf_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      total++; if (app_en !== 1'b1 || app_cmd !== 3'b000 || app_addr !== 27'h200 || app_wdf_wren !== 1'b0) begin bad++; $display("FAIL bp_cmd_hold%0d got=%0b/%0b/%h/%0b", i, app_en, app_cmd, app_addr, app_wdf_wren); end
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_no_resp%0d got=%0b exp=0", i, resp_valid); end
    end
    app_rdy = 1'b1; step(); app_rdy = 1'b0;
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL bp_resp got=%0b exp=1", resp_valid); end
    step();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_pulse got=%0b exp=0", resp_valid); end
    total++; if (cmd_cnt !== 1 || wdf_cnt !== 1) begin bad++; $display("FAIL bp_issue_count got=%0d/%0d exp=1/1", cmd_cnt, wdf_cnt); end
  endtask

  task automatic test_reset_mid_read();
    accept(1'b0, 27'h000_0024, 32'd0, "rmr");
    app_rdy = 1'b1; step(); app_rdy = 1'b0;    // now in RD_WAIT
    rst = 1'b1; step();
    total++; if (req_ready !== 1'b0 || app_en !== 1'b0 || resp_valid !== 1'b0) begin bad++; $display("FAIL rmr_outputs got=%0b%0b%0b exp=000", req_ready, app_en, resp_valid); end
    total++; if (app_addr !== 27'd0 || app_cmd !== 3'd0 || app_wdf_mask !== 16'hFFFF || app_wdf_data !== 128'd0) begin bad++; $display("FAIL rmr_values got=%h/%0b/%h", app_addr, app_cmd, app_wdf_mask); end
    rst = 1'b0;
    app_rd_data = {4{32'hBAADF00D}}; app_rd_data_valid = 1'b1; step(); app_rd_data_valid = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rmr_stale got=%0b exp=0", resp_valid); end
    step();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rmr_stale2 got=%0b exp=0", resp_valid); end
    read_mem(27'h000_0038, 27'h30,
             128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 32'h0C0C0C0C, "rmr_next");
  endtask

`ifdef DDR2_BRIDGE_LINE_BUF_EN
  task automatic hit_read(input logic [26:0] a, input logic [31:0] exp, input string nm);
    accept(1'b0, a, 32'd0, nm);
    total++; if (app_en !== 1'b0 || resp_valid !== 1'b0) begin bad++; $display("FAIL %s_t1 got=%0b/%0b exp=0/0", nm, app_en, resp_valid); end
    step();
    total++; if (resp_valid !== 1'b1 || app_en !== 1'b0) begin bad++; $display("FAIL %s_t2 got=%0b/%0b exp=1/0", nm, resp_valid, app_en); end
    total++; if (resp_rdata !== exp) begin bad++; $display("FAIL %s_rdata got=%h exp=%h", nm, resp_rdata, exp); end
    step();
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL %s_done got=%0b/%0b exp=0/1", nm, resp_valid, req_ready); end
  endtask

  task automatic test_line_buf();
    read_mem(27'h000_0040, 27'h40,
             128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0, 32'hA0A0A0A0, "lb_fill");
    hit_read(27'h000_0044, 32'hB1B1B1B1, "lb_hit");
    write_mem(27'h000_0044, 32'hCAFEF00D, 27'h40, 16'hFF0F, "lb_write");
    hit_read(27'h000_0044, 32'hCAFEF00D, "lb_hit_new");
  endtask
`else
  task automatic test_no_buf();
    read_mem(27'h000_003C, 27'h30,
             128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 32'h0D0D0D0D, "nobuf_reread");
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_calib_gating();
    test_read_ws();
    test_write_mask();
    test_backpressure();
    test_reset_mid_read();
`ifdef DDR2_BRIDGE_LINE_BUF_EN
    test_line_buf();
`else
    test_no_buf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr2_bridge.md
# ddr2_bridge

Memory-side responder for the data cache's miss path. Accepts single-word read and write requests from the cache controller (byte address, 32-bit data) and turns them into command and data transactions on a MIG-style DDR2 user interface with 128-bit lines. Returns read data or write acknowledgement to the cache as a one-cycle response pulse. Sits between the cache and the DDR2 controller IP.

## Interface
Parameters:
- `LINE_W`, 128: MIG user data width. Only 128 is supported.

Ports:
- `clk` in 1: single clock, shared with the MIG user interface (`ui_clk` domain).
- `rst` in 1: synchronous, active-high reset.
- `init_calib_complete` in 1: MIG calibration done.
- `req_valid` in 1: cache request valid.
- `req_ready` out 1: request accepted when both `req_valid` and `req_ready` are high.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 27: byte address; bits [1:0] are ignored.
- `req_wdata` in 32: write data.
- `resp_valid` out 1: one-cycle pulse; no backpressure.
- `resp_rdata` out 32: read data, valid with `resp_valid`; 0 for writes.
- `app_addr` out 27, `app_cmd` out 3 (000 = write, 001 = read), `app_en` out 1, `app_rdy` in 1.
- `app_wdf_data` out 128, `app_wdf_mask` out 16 (1 = byte masked), `app_wdf_wren` out 1, `app_wdf_end` out 1, `app_wdf_rdy` in 1.
- `app_rd_data` in 128, `app_rd_data_valid` in 1.

## Operation
- Address mapping:
  - `app_addr = {req_addr[26:4], 4'b0000}`.
  - Word select `ws = req_addr[3:2]`; word `ws` occupies `line[32*ws +: 32]`.
- Request capture: the address, write flag and write data are latched on acceptance. `req_ready` is high only in IDLE with `init_calib_complete` = 1.
- States:
  - **IDLE**: on accept, go to RD_CMD (read) or WR_DATA (write).
  - **RD_CMD**: `app_en` = 1, `app_cmd` = 001. Hold until `app_rdy` = 1, then go to RD_WAIT.
  - **RD_WAIT**: on `app_rd_data_valid`, latch word `ws` and go to RESP.
  - **WR_DATA**: `app_wdf_wren` = `app_wdf_end` = 1. `app_wdf_data` carries `req_wdata` replicated in all four words. `app_wdf_mask` = all 1s except the 4 bits of word `ws`, which are 0. Hold until `app_wdf_rdy` = 1, then go to WR_CMD.
  - **WR_CMD**: `app_en` = 1, `app_cmd` = 000. Hold until `app_rdy` = 1, then go to RESP.
  - **RESP**: `resp_valid` = 1 for exactly one cycle, then return to IDLE.
- `app_en`, `app_wdf_wren` and `app_wdf_end` are deasserted in every state not listed above.
- `app_rd_data_valid` is ignored outside RD_WAIT.
- Only one request is outstanding at a time; the cache must not expect pipelining.
- `app_addr`, `app_cmd`, `app_wdf_data` and `app_wdf_mask` hold stable while their strobe is high and not yet accepted.

## Timing
- Reset values:
  - `req_ready` = 0, `resp_valid` = 0, `resp_rdata` = 0.
  - `app_en` = 0, `app_wdf_wren` = 0, `app_wdf_end` = 0.
  - `app_addr` = 0, `app_cmd` = 0, `app_wdf_data` = 0, `app_wdf_mask` = 16'hFFFF.
  - State = IDLE.
- All outputs are registered.
- Read, accepted at cycle T:
  - `app_en` is high from T+1.
  - If `app_rdy` is seen at cycle C, RD_WAIT starts at C+1.
  - `app_rd_data_valid` at cycle D gives `resp_valid` at D+1.
  - Minimum case (`app_rdy` at T+1, data valid at T+2): `resp_valid` at T+3.
- Write, accepted at cycle T:
  - `app_wdf_wren` is high from T+1.
  - If `app_rdy` in WR_CMD is seen at cycle C, `resp_valid` is at C+1.
  - Minimum latency is T+3.
- `req_ready` is low from T+1 until the cycle after RESP.
- Reset mid-transaction returns the block to IDLE on the next edge.
  - Pending read data that arrives later is ignored.
  - The cache must reissue the request.
- If `init_calib_complete` drops while a transaction is in flight, the transaction completes; new requests are blocked.

## Configuration
- Macro: `DDR2_BRIDGE_LINE_BUF_EN`.
- Defined: a one-entry line buffer holds the 128-bit line and tag `addr[26:4]` from the last read.
  - Read accepted with a valid buffer and matching tag: go directly to RESP, so `resp_valid` is at T+2 with no `app_en`.
  - Write to the buffered line: update word `ws` in the buffer as well as memory.
  - Reset invalidates the buffer.
- Undefined: no buffer; every read goes to memory.

## Test plan
- Calibration gating: hold `init_calib_complete` = 0 with `req_valid` = 1 → `req_ready` stays 0 and `app_en` stays 0. Raise calibration → request accepted in the next cycle.
- Read, word select: `req_addr` = 27'h0000_01C, with the line returning 128'h4444…_3333…_2222…_1111… → `app_addr` = 27'h10, `resp_rdata` = 32'h44444444, one-cycle `resp_valid`.
- Write mask: write 32'hDEADBEEF to 27'h0000_108 → `app_wdf_mask` = 16'hF0FF, `app_cmd` = 000, `app_addr` = 27'h100, `resp_valid` once.
- Backpressure: `app_wdf_rdy` low for 5 cycles, then `app_rdy` low for 3 cycles → strobes and data held stable throughout, exactly one write issued, `resp_valid` at the cycle after `app_rdy`.
- Reset mid-read: assert `rst` in RD_WAIT, then pulse `app_rd_data_valid` → no `resp_valid`; all outputs at reset values; next read completes correctly.
- With `DDR2_BRIDGE_LINE_BUF_EN`: read 27'h40, read 27'h44 → second response at T+2 with no `app_en`. Then write 27'h44, read 27'h44 → returns the new data.
